prf_rd_arb: RTL and testbench

PRF_RD_ARB -- requirements
Module: prf_rd_arb

---
 rtl/rename_defs.sv | 33 +++
 rtl/prf_rd_pick.sv | 87 ++++++++
 rtl/prf_rd_arb.sv | 104 ++++++++++
 tb/tb_prf_rd_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_defs.sv
// rtl/rename_defs.sv - shared rename/PRF types for the PRF read-port arbiter
//
// Purpose: physical-register and data types, the flush packet and the
// per-port read route record used by prf_rd_arb / prf_rd_pick.
// Ports: none (package).
package rename_defs;

  localparam int PRF_ID_W        = 7;   // 128 physical registers
  localparam int RV_XLEN         = 32;
  localparam int PRF_RD_PORTS    = 2;   // PRF read ports shared by the requesters
  localparam int PRF_RD_REQ_ID_W = 2;   // route record holds up to 4 requester ids

  typedef logic [PRF_ID_W-1:0] t_prf_id;
  typedef logic [RV_XLEN-1:0]  t_rv_reg_data;

  typedef struct packed {
    logic valid;
  } t_nuke_pkt;

  // One record per PRF read port: which requester/source the port's data
  // belongs to when it comes back a cycle later.
  typedef struct packed {
    logic                       valid;
    logic [PRF_RD_REQ_ID_W-1:0] req_id;
    logic                       src_idx;
  } t_prf_rd_route;

  // Number of read ports a request needs (0..2).
  function automatic int src_need(input logic en0, input logic en1);
    return int'(en0) + int'(en1);
  endfunction

endpackage

// File: rtl/prf_rd_pick.sv
// rtl/prf_rd_pick.sv - combinational rotating-priority pick and port packing
//
// Purpose: visits requesters starting at rr_ptr, grants every requester whose
// port need fits the remaining free ports (skipping ones that do not fit),
// and packs granted sources onto the lowest free ports.
// Ports:
//   rr_ptr    in   current highest-priority requester
//   req       in   [NUM_REQ] request (already masked by flush)
//   srcen     in   [NUM_REQ][2] per-source read enable
//   psrc      in   [NUM_REQ][2] per-source physical register
//   gnt       out  [NUM_REQ] grant
//   rden      out  [RD_PORTS] read-port enable
//   rdaddr    out  [RD_PORTS] read-port address (0 when idle)
//   route     out  [RD_PORTS] route record for the rd1 return path
//   any_gnt   out  at least one grant this cycle
//   next_ptr  out  first-granted index + 1 (mod NUM_REQ)
module prf_rd_pick
  import rename_defs::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int RD_PORTS = PRF_RD_PORTS,
  parameter int RR_W     = 1
) (
  input  logic [RR_W-1:0] rr_ptr,
  input  logic            req      [NUM_REQ],
  input  logic            srcen    [NUM_REQ][2],
  input  t_prf_id         psrc     [NUM_REQ][2],
  output logic            gnt      [NUM_REQ],
  output logic            rden     [RD_PORTS],
  output t_prf_id         rdaddr   [RD_PORTS],
  output t_prf_rd_route   route    [RD_PORTS],
  output logic            any_gnt,
  output logic [RR_W-1:0] next_ptr
);

  always_comb begin
    int                  free;
    int                  need;
    logic [RR_W-1:0]     idx;
    logic [RD_PORTS-1:0] used;
    logic                taken;

    for (int i = 0; i < NUM_REQ; i++) gnt[i] = 1'b0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rden[p]   = 1'b0;
      rdaddr[p] = '0;
      route[p]  = '0;
    end
    any_gnt  = 1'b0;
    next_ptr = rr_ptr;
    free     = RD_PORTS;
    used     = '0;
    taken    = 1'b0;
    idx      = '0;
    need     = 0;

    for (int k = 0; k < NUM_REQ; k++) begin
      idx  = RR_W'((int'(rr_ptr) + k) % NUM_REQ);
      need = src_need(srcen[idx][0], srcen[idx][1]);
      // A non-fitting requester is skipped, later ones may still pack in.
      if (req[idx] && need <= free) begin
        gnt[idx] = 1'b1;
        if (!any_gnt) next_ptr = RR_W'((int'(idx) + 1) % NUM_REQ);
        any_gnt = 1'b1;
        free    = free - need;
        for (int s = 0; s < 2; s++) begin
          if (srcen[idx][s]) begin
            // Lowest unused port wins; 'taken' stops the search at the first hit.
            taken = 1'b0;
            for (int p = 0; p < RD_PORTS; p++) begin
              if (!taken && !used[p]) begin
                taken           = 1'b1;
                used[p]         = 1'b1;
                rden[p]         = 1'b1;
                rdaddr[p]       = psrc[idx][s];
                route[p].valid  = 1'b1;
                route[p].req_id = PRF_RD_REQ_ID_W'(idx);
                route[p].src_idx = 1'(s);
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/prf_rd_arb.sv
// rtl/prf_rd_arb.sv - PRF read-port arbiter between reservation stations
//
// Purpose: same-cycle grant of the shared PRF read ports (rd0), registered
// route table, and routing of the returned PRF data to requesters (rd1).
// The pick logic supports exactly two read ports' worth of sources per request.
// Ports:
//   clk             in   clock
//   reset           in   asynchronous active-low reset
//   nuke_rb1        in   flush; blocks grants and suppresses responses
//   req_rd0         in   [NUM_REQ] read request
//   req_srcen_rd0   in   [NUM_REQ][2] per-source enable
//   req_psrc_rd0    in   [NUM_REQ][2] per-source physical register
//   gnt_rd0         out  [NUM_REQ] same-cycle grant
//   prf_rden_rd0    out  [RD_PORTS] PRF read enable
//   prf_rdaddr_rd0  out  [RD_PORTS] PRF read address
//   prf_rddata_rd1  in   [RD_PORTS] PRF read data (one cycle after enable)
//   rsp_valid_rd1   out  [NUM_REQ] response valid
//   rsp_data_rd1    out  [NUM_REQ][2] per-source response data
module prf_rd_arb
  import rename_defs::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int RD_PORTS = PRF_RD_PORTS
) (
  input  logic          clk,
  input  logic          reset,
  input  t_nuke_pkt     nuke_rb1,
  input  logic          req_rd0        [NUM_REQ],
  input  logic          req_srcen_rd0  [NUM_REQ][2],
  input  t_prf_id       req_psrc_rd0   [NUM_REQ][2],
  output logic          gnt_rd0        [NUM_REQ],
  output logic          prf_rden_rd0   [RD_PORTS],
  output t_prf_id       prf_rdaddr_rd0 [RD_PORTS],
  input  t_rv_reg_data  prf_rddata_rd1 [RD_PORTS],
  output logic          rsp_valid_rd1  [NUM_REQ],
  output t_rv_reg_data  rsp_data_rd1   [NUM_REQ][2]
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [RR_W-1:0] rr_ptr;
  logic [RR_W-1:0] next_ptr;
  logic            any_gnt;
  logic            req_live [NUM_REQ];
  t_prf_rd_route   route    [RD_PORTS];
  t_prf_rd_route   route_q  [RD_PORTS];
  logic            gnt_q    [NUM_REQ];

  // Flush masks requests at the source, so grants, enables and the pointer
  // update all go quiet together.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_live[i] = req_rd0[i] && !nuke_rb1.valid;
  end

  prf_rd_pick #(
    .NUM_REQ  (NUM_REQ),
    .RD_PORTS (RD_PORTS),
    .RR_W     (RR_W)
  ) u_pick (
    .rr_ptr   (rr_ptr),
    .req      (req_live),
    .srcen    (req_srcen_rd0),
    .psrc     (req_psrc_rd0),
    .gnt      (gnt_rd0),
    .rden     (prf_rden_rd0),
    .rdaddr   (prf_rdaddr_rd0),
    .route    (route),
    .any_gnt  (any_gnt),
    .next_ptr (next_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) gnt_q[i] <= 1'b0;
      for (int p = 0; p < RD_PORTS; p++) route_q[p] <= '0;
    end else begin
      if (any_gnt) rr_ptr <= next_ptr;
      for (int i = 0; i < NUM_REQ; i++) gnt_q[i] <= gnt_rd0[i];
      for (int p = 0; p < RD_PORTS; p++) route_q[p] <= route[p];
    end
  end

  // rd1 return path: each port's data goes to the (requester, source) its
  // route record names; sources no port maps to read as zero.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_rd1[i] = gnt_q[i] && !nuke_rb1.valid;
      for (int s = 0; s < 2; s++) rsp_data_rd1[i][s] = '0;
    end
    for (int p = 0; p < RD_PORTS; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int s = 0; s < 2; s++) begin
          if (route_q[p].valid &&
              route_q[p].req_id == PRF_RD_REQ_ID_W'(i) &&
              route_q[p].src_idx == 1'(s)) begin
            rsp_data_rd1[i][s] = prf_rddata_rd1[p];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_rd_arb.sv
// tb/tb_prf_rd_arb.sv - self-checking bench for prf_rd_arb
module tb_prf_rd_arb;
  import rename_defs::*;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset;
  t_nuke_pkt    nuke;
  logic         req       [N];
  logic         srcen     [N][2];
  t_prf_id      psrc      [N][2];
  logic         gnt       [N];
  logic         rden      [2];
  t_prf_id      addr      [2];
  t_rv_reg_data rdata     [2];
  logic         rsp_valid [N];
  t_rv_reg_data rsp_data  [N][2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prf_rd_arb #(.NUM_REQ(N), .RD_PORTS(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .nuke_rb1       (nuke),
    .req_rd0        (req),
    .req_srcen_rd0  (srcen),
    .req_psrc_rd0   (psrc),
    .gnt_rd0        (gnt),
    .prf_rden_rd0   (rden),
    .prf_rdaddr_rd0 (addr),
    .prf_rddata_rd1 (rdata),
    .rsp_valid_rd1  (rsp_valid),
    .rsp_data_rd1   (rsp_data)
  );

  function automatic t_rv_reg_data prf_val(input t_prf_id a);
    return 32'hDA7A_0000 + 32'(a) * 32'd257;
  endfunction

  // PRF behaviour: data for the address read last cycle; idle ports carry junk.
  logic    q_en   [2];
  t_prf_id q_addr [2];
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      q_en[p]   <= rden[p];
      q_addr[p] <= addr[p];
    end
  end
  always_comb begin
    for (int p = 0; p < 2; p++)
      rdata[p] = q_en[p] ? prf_val(q_addr[p]) : (32'hBAD0_0000 + 32'(p));
  end

  // Model: walk requesters in priority order, hand out ports in sequence.
  int           m_ptr;
  logic         m_pend_gnt  [N];
  t_rv_reg_data m_pend_data [N][2];
  logic         e_gnt  [N];
  logic         e_rden [2];
  t_prf_id      e_addr [2];
  int           e_next_ptr;
  logic         e_any;

  always_comb begin
    int used;
    int need;
    for (int j = 0; j < N; j++) e_gnt[j] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      e_rden[p] = 1'b0;
      e_addr[p] = '0;
    end
    e_any      = 1'b0;
    e_next_ptr = m_ptr;
    used       = 0;
    need       = 0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (j == (m_ptr + k) % N) begin
          need = (srcen[j][0] ? 1 : 0) + (srcen[j][1] ? 1 : 0);
          if (req[j] && !nuke.valid && used + need <= 2) begin
            e_gnt[j] = 1'b1;
            if (!e_any) e_next_ptr = (j + 1) % N;
            e_any = 1'b1;
            for (int s = 0; s < 2; s++) begin
              if (srcen[j][s]) begin
                for (int p = 0; p < 2; p++) begin
                  if (p == used) begin
                    e_rden[p] = 1'b1;
                    e_addr[p] = psrc[j][s];
                  end
                end
                used = used + 1;
              end
            end
          end
        end
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ptr <= 0;
      for (int i = 0; i < N; i++) begin
        m_pend_gnt[i] <= 1'b0;
        for (int s = 0; s < 2; s++) m_pend_data[i][s] <= '0;
      end
    end else begin
      m_ptr <= e_next_ptr;
      for (int i = 0; i < N; i++) begin
        m_pend_gnt[i] <= e_gnt[i];
        for (int s = 0; s < 2; s++)
          m_pend_data[i][s] <= (e_gnt[i] && srcen[i][s]) ? prf_val(psrc[i][s]) : '0;
      end
    end
  end

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) check("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
    end else begin
      for (int i = 0; i < N; i++) begin
        check("gnt", i, 32'(gnt[i]), 32'(e_gnt[i]));
        check("rsp_valid", i, 32'(rsp_valid[i]), 32'(m_pend_gnt[i] && !nuke.valid));
        for (int s = 0; s < 2; s++) check("rsp_data", i * 2 + s, rsp_data[i][s], m_pend_data[i][s]);
      end
      for (int p = 0; p < 2; p++) begin
        check("rden", p, 32'(rden[p]), 32'(e_rden[p]));
        check("rdaddr", p, 32'(addr[p]), 32'(e_addr[p]));
      end
    end
  end

  task automatic idle();
    nuke.valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        srcen[i][s] = 1'b0;
        psrc[i][s]  = '0;
      end
    end
  endtask

  task automatic drive(input logic r0, input logic [1:0] e0, input int a00, input int a01,
                       input logic r1, input logic [1:0] e1, input int a10, input int a11,
                       input logic nk);
    req[0] = r0; srcen[0][0] = e0[0]; srcen[0][1] = e0[1];
    psrc[0][0] = t_prf_id'(a00); psrc[0][1] = t_prf_id'(a01);
    req[1] = r1; srcen[1][0] = e1[0]; srcen[1][1] = e1[1];
    psrc[1][0] = t_prf_id'(a10); psrc[1][1] = t_prf_id'(a11);
    nuke.valid = nk;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    next_cycle();

    // single requester, two sources
    drive(1, 2'b11, 5, 9, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    check("t1_gnt", 0, 32'(gnt[0]), 32'd1);
    check("t1_gnt", 1, 32'(gnt[1]), 32'd0);
    check("t1_addr", 0, 32'(addr[0]), 32'd5);
    check("t1_addr", 1, 32'(addr[1]), 32'd9);
    next_cycle(); idle();
    @(negedge clk);
    check("t1_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
    check("t1_rsp_data", 0, rsp_data[0][0], 32'hDA7A_0505);
    check("t1_rsp_data", 1, rsp_data[0][1], 32'hDA7A_0909);

    // pointer is at 1: one grant to req1 brings it back to 0
    next_cycle();
    drive(0, 2'b00, 0, 0, 1, 2'b01, 2, 0, 0);
    @(negedge clk);
    check("steer_gnt", 1, 32'(gnt[1]), 32'd1);
    next_cycle();

    // packing: one source each
    drive(1, 2'b01, 3, 0, 1, 2'b10, 0, 7, 0);
    @(negedge clk);
    check("t2_gnt", 0, 32'(gnt[0]), 32'd1);
    check("t2_gnt", 1, 32'(gnt[1]), 32'd1);
    check("t2_addr", 0, 32'(addr[0]), 32'd3);
    check("t2_addr", 1, 32'(addr[1]), 32'd7);
    next_cycle(); idle();
    @(negedge clk);
    check("t2_rsp_data0", 0, rsp_data[0][0], 32'hDA7A_0303);
    check("t2_rsp_data1", 1, rsp_data[1][1], 32'hDA7A_0707);
    check("t2_rsp_data1", 0, rsp_data[1][0], 32'd0);

    // pointer is at 1 again: steer back to 0
    next_cycle();
    drive(0, 2'b00, 0, 0, 1, 2'b11, 10, 11, 0);
    next_cycle();

    // contention: grants alternate 0,1,0,1
    for (int c = 0; c < 4; c++) begin
      drive(1, 2'b11, 20, 21, 1, 2'b11, 30, 31, 0);
      @(negedge clk);
      check("t3_gnt0", c, 32'(gnt[0]), (c % 2 == 0) ? 32'd1 : 32'd0);
      check("t3_gnt1", c, 32'(gnt[1]), (c % 2 == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end

    // flush: grant req1, then nuke the following cycle
    drive(0, 2'b00, 0, 0, 1, 2'b11, 40, 41, 0);
    @(negedge clk);
    check("t4_gnt", 1, 32'(gnt[1]), 32'd1);
    next_cycle();
    drive(1, 2'b11, 42, 43, 1, 2'b11, 44, 45, 1);
    @(negedge clk);
    check("t4_nuke_gnt", 0, 32'(gnt[0]), 32'd0);
    check("t4_nuke_gnt", 1, 32'(gnt[1]), 32'd0);
    check("t4_nuke_rden", 0, 32'(rden[0]), 32'd0);
    check("t4_nuke_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
    next_cycle();
    drive(1, 2'b11, 42, 43, 1, 2'b11, 44, 45, 0);
    @(negedge clk);
    check("t4_after_gnt", 0, 32'(gnt[0]), 32'd1);
    next_cycle();

    // reset with a grant in flight (pointer would otherwise move to 1)
    drive(1, 2'b11, 50, 51, 0, 2'b00, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    idle();
    @(negedge clk);
    check("t5_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    drive(1, 2'b11, 52, 53, 1, 2'b11, 54, 55, 0);
    @(negedge clk);
    check("t5_ptr_gnt", 0, 32'(gnt[0]), 32'd1);
    check("t5_ptr_gnt", 1, 32'(gnt[1]), 32'd0);
    next_cycle();

    // zero-source request alongside a two-source request
    drive(1, 2'b00, 0, 0, 1, 2'b11, 12, 13, 0);
    @(negedge clk);
    check("t6_gnt", 0, 32'(gnt[0]), 32'd1);
    check("t6_gnt", 1, 32'(gnt[1]), 32'd1);
    check("t6_addr", 0, 32'(addr[0]), 32'd12);
    check("t6_addr", 1, 32'(addr[1]), 32'd13);
    next_cycle(); idle();
    @(negedge clk);
    check("t6_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
    check("t6_rsp_data1", 0, rsp_data[1][0], 32'hDA7A_0C0C);
    check("t6_rsp_data1", 1, rsp_data[1][1], 32'hDA7A_0D0D);
    check("t6_rsp_data0", 0, rsp_data[0][0], 32'd0);
    next_cycle();

    // mixed traffic against the model
    for (int c = 0; c < 80; c++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
            ($urandom_range(0, 7) == 0));
      next_cycle();
    end
    idle();
    repeat (2) next_cycle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
